// File: rtl/not_gate_arbiter_if.sv
// not_gate_arbiter_if: requester and shared-cell signals of the inverter arbiter
interface not_gate_arbiter_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0] req, req_data, gnt, ack;
  logic ack_data, err, busy, gate_inp, gate_out;
  modport master(output req, req_data, gate_out, input gnt, ack, ack_data, err, busy, gate_inp);
  modport slave(input req, req_data, gate_out, output gnt, ack, ack_data, err, busy, gate_inp);
endinterface

// File: rtl/not_gate_arbiter.sv
// not_gate_arbiter: round-robin sharing of one gate_not cell with settle, capture and fault flag
module not_gate_arbiter #(
  parameter int N_REQ = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input logic clk,
  input logic rst,
  not_gate_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;
  state_t state;
  logic [IW-1:0] ptr, win, pick;
  logic [3:0] cnt;
  logic [N_REQ-1:0] mask, elig;
  logic bit_l;
  // lowest eligible index overall, overridden by the lowest one at or above ptr
  always_comb begin
    elig = bus.req & ~mask;
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) if (elig[i]) pick = IW'(i);
    for (int i = N_REQ - 1; i >= 0; i--) if (elig[i] && i >= int'(ptr)) pick = IW'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.gnt <= '0;
      bus.ack <= '0;
      bus.ack_data <= 1'b0;
      bus.err <= 1'b0;
      bus.busy <= 1'b0;
      bus.gate_inp <= 1'b0;
      ptr <= '0;
      win <= '0;
      cnt <= '0;
      mask <= '0;
      bit_l <= 1'b0;
    end else begin
      bus.ack <= '0;
      bus.ack_data <= 1'b0;
      bus.err <= 1'b0;
      mask <= '0;
      case (state)
        IDLE: if (|elig) begin
          bus.gnt <= N_REQ'(1) << pick;
          bit_l <= bus.req_data[pick];
          bus.gate_inp <= bus.req_data[pick];
          bus.busy <= 1'b1;
          win <= pick;
          cnt <= 4'(SETTLE_CYCLES);
          state <= SETTLE;
        end
        SETTLE: begin
          cnt <= cnt - 4'd1;
          state <= cnt == 4'd1 ? CAPTURE : SETTLE;
        end
        CAPTURE: begin
          bus.ack <= N_REQ'(1) << win;
          bus.ack_data <= bus.gate_out;
          // case inequality so an X or Z from the cell is reported as a fault
          bus.err <= bus.gate_out !== ~bit_l;
          bus.gnt <= '0;
          bus.busy <= 1'b0;
          ptr <= win == IW'(N_REQ - 1) ? '0 : win + 1'b1;
          mask <= N_REQ'(1) << win;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/not_gate_arbiter.md
# not_gate_arbiter

Round-robin arbiter and sequencer that shares one switch-level `gate_not` cell between `N_REQ` requesters. It grants the cell to one requester at a time and drives that requester's bit onto the cell input. After a programmable settle window it samples the cell output and returns the result with a one-cycle acknowledge. It also flags any result that is not the logical inverse of the driven bit, so it doubles as a fault monitor for the transistor-level inverter.

## Interface
- `N_REQ`, default 4: number of requesters; range 2..8.
- `SETTLE_CYCLES`, default 1: cycles the cell input is held before sampling; range 1..15.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `req`  input  N_REQ  per-requester request level; held high until own `ack`.
- `req_data`  input  N_REQ  per-requester bit to invert; sampled only at grant.
- `gnt`  output  N_REQ  one-hot grant; at most one bit high.
- `ack`  output  N_REQ  one-hot, one-cycle completion pulse.
- `ack_data`  output  1  captured cell output; valid only while any `ack` bit is high.
- `err`  output  1  one-cycle pulse with `ack` when the captured value is not the inverse of the latched bit.
- `busy`  output  1  high in SETTLE and CAPTURE.
- `gate_inp`  output  1  drives the shared `gate_not` input.
- `gate_out`  input  1  from the shared `gate_not` output.

## Operation
- States: IDLE, SETTLE, CAPTURE. All outputs are registered.
- Reset values: state=IDLE, `gnt`=0, `ack`=0, `ack_data`=0, `err`=0, `busy`=0, `gate_inp`=0, round-robin pointer=0, settle counter=0, mask=0.
- **IDLE:**
  - Compute eligible = `req` & ~mask. If eligible is 0, stay in IDLE.
  - Otherwise the winner is the first eligible index at or above the pointer, wrapping modulo `N_REQ`.
  - Register `gnt`=onehot(winner), latch `req_data[winner]`, and set `gate_inp` to the latched bit.
  - Load the counter with `SETTLE_CYCLES` and go to SETTLE.
- **SETTLE:**
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to CAPTURE. SETTLE therefore lasts exactly `SETTLE_CYCLES` cycles.
- **CAPTURE** (one cycle):
  - Sample `gate_out`.
  - Register `ack`=onehot(winner), `ack_data`=sample, and `err`=(sample != ~latched bit). In simulation `err` is also asserted when `gate_out` is X or Z.
  - Clear `gnt`, set pointer=(winner+1) mod `N_REQ`, set mask=onehot(winner), and go to IDLE.
- Mask:
  - The mask is valid only for the single IDLE cycle in which `ack` is high. It clears unconditionally at the next edge.
  - This prevents re-granting a requester whose `req` is still high in its ack cycle.
- `gate_inp` holds its last driven value in IDLE. It never changes during SETTLE or CAPTURE.
- A requester that drops `req` mid-transaction does not abort it. The transaction completes and `ack` is still issued.
- `req_data` changes after grant are ignored.
- Reset asserted in any state aborts the transaction. All outputs take their reset values at that edge, and no `ack` is issued for the aborted grant.

## Timing
- Request sampled in IDLE at edge t:
  - `gnt` and `gate_inp` are valid after edge t.
  - CAPTURE occupies cycle t+`SETTLE_CYCLES`+1.
  - `ack`, `ack_data` and `err` are high for exactly the one cycle after edge t+`SETTLE_CYCLES`+1.
- Request-to-ack latency is `SETTLE_CYCLES`+2 edges.
- The ack cycle is an IDLE cycle and may grant a different requester. Peak throughput is one transaction per `SETTLE_CYCLES`+2 cycles.
- `gnt` is high from the grant edge to the CAPTURE edge, and never overlaps `ack` for the same requester.
- `busy` = state ∈ {SETTLE, CAPTURE}.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `req`=4'b1111 -> all outputs 0 and no grant. Release -> `gnt`=4'b0001 on the next edge.
- **Single request**, `N_REQ`=4, `SETTLE_CYCLES`=1, real `gate_not` attached: `req`=4'b0100 and `req_data`=4'b0100 at edge 0 -> `gnt`=4'b0100 and `gate_inp`=1 after edge 0; `ack`=4'b0100, `ack_data`=0, `err`=0 after edge 2; nothing is re-granted while `req[2]` stays high during the ack cycle.
- **Round-robin fairness:** hold `req`=4'b1011 continuously -> grant order 0,1,3,0,1,3. Each ack cycle coincides with the next `gnt`.
- **Fault detection:** replace the cell with a stuck-at-1 model and drive `req_data[1]`=1 -> `ack_data`=1 and `err`=1 with `ack`=4'b0010. Drive `req_data[1]`=0 -> `err`=0.
- **Reset mid-operation:** with `SETTLE_CYCLES`=3, assert `rst` one cycle into SETTLE -> `gnt`=0, `gate_inp`=0 and `busy`=0 at the next edge, and no `ack` afterwards.
- **Request drop and data change:** drop `req[3]` and toggle `req_data[3]` during SETTLE -> `ack[3]` still pulses after `SETTLE_CYCLES`+2 edges, and `ack_data` is the inverse of the bit latched at grant.
